sign_sum_diff_decoder: RTL and testbench
========================================

SIGN_SUM_DIFF_DECODER -- requirements
Module: sign_sum_diff_decoder

Interface
REQ-001 Parameter: INPUT_BIT_WIDTH, default 8, signed width W of the recovered operands.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Rst  input  1  reset, synchronous, active-high.
REQ-004 InputA  input  W+1  two's-complement sum or difference word, selected by AddSubMode.
REQ-005 InputB  input  W+1  two's-complement difference or sum word, the complement of InputA's role.
REQ-006 AddSubMode  input  1  1: InputA=sum, InputB=diff; 0: InputA=diff, InputB=sum.
REQ-007 InValid  input  1  input word pair valid.
REQ-008 InReady  output  1  block accepts the pair this cycle.
REQ-009 ResultA  output  W  recovered operand A = (sum+diff)/2, signed.
REQ-010 ResultB  output  W  recovered operand B = (sum-diff)/2, signed.
REQ-011 ErrParity  output  1  sum and diff LSBs differ; pair not produced by an exact add/sub.
REQ-012 ErrOverflow  output  1  A or B is outside the signed W-bit range.
REQ-013 OutValid  output  1  result and flags valid.
REQ-014 OutReady  input  1  downstream accepts the result.

Function
REQ-015 Input transfer on InValid&&InReady; output transfer on OutValid&&OutReady.
REQ-016 Two-stage pipeline: stage 1 registers W+2-bit signed (sum+diff), (sum-diff), parity = sum[0]^diff[0]; stage 2 registers shifted, truncated results and flags.
REQ-017 Stage 2 arithmetic: ResultA = (sum+diff)>>>1, ResultB = (sum-diff)>>>1 (floor); truncated to W bits.
REQ-018 ErrOverflow = 1 when either shifted W+1-bit value differs from the sign-extension of its W-bit truncation.
REQ-019 Latency: an input accepted in cycle N produces OutValid in cycle N+2 when stages are empty.
REQ-020 Each stage holds one entry; a stage loads when empty or when its content moves downstream in the same cycle.
REQ-021 InReady = !stage1_valid || (stage1 advances this cycle); combinational from OutReady permitted.
REQ-022 With OutReady held low: 2 pairs buffered; InReady deasserts; ResultA/ResultB/flags/OutValid stay stable until transfer.
REQ-023 Simultaneous input and output transfer with a full pipe: both complete; throughput 1 pair/cycle.
REQ-024 AddSubMode is sampled with its pair at input transfer only.
REQ-025 ErrParity set: results still produced using the floor rule; no stall.

Reset
REQ-026 Rst=1 at a rising edge clears both stage valids; OutValid=0, ResultA=0, ResultB=0, ErrParity=0, ErrOverflow=0.
REQ-027 InReady=0 while Rst=1; in-flight pairs are discarded, not emitted.
REQ-028 First pair is accepted in the cycle after Rst deasserts.

Configuration
REQ-029 Macro SIGN_SUM_DIFF_DECODER_ERR_EN defined: parity and overflow logic per REQ-011/012/018.
REQ-030 Macro SIGN_SUM_DIFF_DECODER_ERR_EN undefined: ErrParity and ErrOverflow ports remain and are tied 0; no flag registers; datapath and timing unchanged.

Verification (W=8, ERR_EN defined unless noted)
REQ-031 Mode=1, A=+10, B=+4, OutReady=1 -> 2 cycles later ResultA=7, ResultB=3, flags 0.
REQ-032 Mode=0, A=-4 (diff), B=+10 (sum) -> ResultA=3, ResultB=7; Mode=1, A=5, B=2 -> ErrParity=1, ResultA=3, ResultB=1.
REQ-033 Mode=1, A=255, B=-1 -> ResultA=127, ResultB=-128 (truncated 128), ErrOverflow=1; ERR_EN undefined -> ErrOverflow=0.
REQ-034 OutReady=0 for 4 cycles, InValid=1 with 3 pairs -> 2 accepted, InReady=0, outputs stable; OutReady=1 -> all 3 emitted in order.
REQ-035 Rst pulsed with 2 pairs in flight -> next cycle OutValid=0, all outputs 0, no stale pair emitted afterward.

Source files
------------

// File: rtl/sign_sum_diff_decoder.sv
// Recovers signed operands A and B from a sum/difference word pair in two pipeline stages.
// Flag logic is built only when SIGN_SUM_DIFF_DECODER_ERR_EN is defined; otherwise the flags are tied to 0.
module sign_sum_diff_decoder #(
    parameter int INPUT_BIT_WIDTH = 8
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [INPUT_BIT_WIDTH:0]   InputA,
    input  logic [INPUT_BIT_WIDTH:0]   InputB,
    input  logic                       AddSubMode,
    input  logic                       InValid,
    output logic                       InReady,
    output logic [INPUT_BIT_WIDTH-1:0] ResultA,
    output logic [INPUT_BIT_WIDTH-1:0] ResultB,
    output logic                       ErrParity,
    output logic                       ErrOverflow,
    output logic                       OutValid,
    input  logic                       OutReady
);
    localparam int W = INPUT_BIT_WIDTH;

    logic         s1_valid_q, s1_valid_d;
    logic [W+1:0] s1_add_q, s1_add_d;
    logic [W+1:0] s1_sub_q, s1_sub_d;
    logic         s2_valid_q, s2_valid_d;
    logic [W-1:0] res_a_q, res_a_d;
    logic [W-1:0] res_b_q, res_b_d;

    logic [W:0]   sum_w, diff_w;
    logic [W+1:0] sum_x, diff_x;
    logic [W:0]   shift_a, shift_b;
    logic         s2_ready, s1_adv, in_fire;

    always_comb begin
        s2_ready = !s2_valid_q || OutReady;
        s1_adv   = s1_valid_q && s2_ready;
        InReady  = !Rst && (!s1_valid_q || s2_ready);
        in_fire  = InValid && InReady;
    end

    // Stage 1: full-width sum and difference, sign-extended to avoid overflow
    always_comb begin
        sum_w      = AddSubMode ? InputA : InputB;
        diff_w     = AddSubMode ? InputB : InputA;
        sum_x      = {sum_w[W], sum_w};
        diff_x     = {diff_w[W], diff_w};
        s1_add_d   = s1_add_q;
        s1_sub_d   = s1_sub_q;
        if (in_fire) begin
            s1_add_d = sum_x + diff_x;
            s1_sub_d = sum_x - diff_x;
        end
        s1_valid_d = in_fire || (s1_valid_q && !s1_adv);
    end

    // Stage 2: arithmetic shift right by one (floor divide), then truncate
    always_comb begin
        shift_a    = s1_add_q[W+1:1];
        shift_b    = s1_sub_q[W+1:1];
        res_a_d    = res_a_q;
        res_b_d    = res_b_q;
        if (s1_adv) begin
            res_a_d = shift_a[W-1:0];
            res_b_d = shift_b[W-1:0];
        end
        s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            s1_valid_q <= 1'b0;
            s1_add_q   <= '0;
            s1_sub_q   <= '0;
            s2_valid_q <= 1'b0;
            res_a_q    <= '0;
            res_b_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_add_q   <= s1_add_d;
            s1_sub_q   <= s1_sub_d;
            s2_valid_q <= s2_valid_d;
            res_a_q    <= res_a_d;
            res_b_q    <= res_b_d;
        end
    end

`ifdef SIGN_SUM_DIFF_DECODER_ERR_EN
    logic s1_par_q, s1_par_d;
    logic err_par_q, err_par_d;
    logic err_ovf_q, err_ovf_d;
    logic unused_lsb;

    assign unused_lsb = ^{s1_add_q[0], s1_sub_q[0]};

    always_comb begin
        s1_par_d  = s1_par_q;
        err_par_d = err_par_q;
        err_ovf_d = err_ovf_q;
        if (in_fire) begin
            s1_par_d = sum_w[0] ^ diff_w[0];
        end
        if (s1_adv) begin
            err_par_d = s1_par_q;
            err_ovf_d = (shift_a[W] ^ shift_a[W-1]) |
                        (shift_b[W] ^ shift_b[W-1]);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            s1_par_q  <= 1'b0;
            err_par_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            s1_par_q  <= s1_par_d;
            err_par_q <= err_par_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    assign ErrParity   = err_par_q;
    assign ErrOverflow = err_ovf_q;
`else
    logic unused_bits;

    assign unused_bits = ^{s1_add_q[0], s1_sub_q[0],
                           shift_a[W], shift_b[W]};

    assign ErrParity   = 1'b0;
    assign ErrOverflow = 1'b0;
`endif

    assign OutValid = s2_valid_q;
    assign ResultA  = res_a_q;
    assign ResultB  = res_b_q;

endmodule

// File: tb/tb_sign_sum_diff_decoder.sv
// Self-checking bench for sign_sum_diff_decoder (W=8), directed vectors.
module tb_sign_sum_diff_decoder;
    logic       Clk = 1'b0;
    logic       Rst;
    logic [8:0] InputA, InputB;
    logic       AddSubMode, InValid, InReady;
    logic [7:0] ResultA, ResultB;
    logic       ErrParity, ErrOverflow, OutValid, OutReady;

`ifdef SIGN_SUM_DIFF_DECODER_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    sign_sum_diff_decoder #(.INPUT_BIT_WIDTH(8)) dut (
        .Clk(Clk), .Rst(Rst),
        .InputA(InputA), .InputB(InputB),
        .AddSubMode(AddSubMode),
        .InValid(InValid), .InReady(InReady),
        .ResultA(ResultA), .ResultB(ResultB),
        .ErrParity(ErrParity), .ErrOverflow(ErrOverflow),
        .OutValid(OutValid), .OutReady(OutReady)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       mode;
        logic [8:0] a;
        logic [8:0] b;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       par;
        logic       ovf;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        InValid    = 1'b1;
        AddSubMode = v.mode;
        InputA     = v.a;
        InputB     = v.b;
    endtask

    task automatic chk_out(input string name, input vec_t v);
        chk({name, " valid"}, {31'd0, OutValid}, 32'd1);
        chk({name, " ResultA"}, {24'd0, ResultA}, {24'd0, v.ra});
        chk({name, " ResultB"}, {24'd0, ResultB}, {24'd0, v.rb});
        chk({name, " ErrParity"}, {31'd0, ErrParity}, {31'd0, v.par & ERR});
        chk({name, " ErrOverflow"}, {31'd0, ErrOverflow}, {31'd0, v.ovf & ERR});
    endtask

    initial begin
        int k;
        vecs[0] = '{1'b1, 9'd10,   9'd4,   8'd7,   8'd3,   1'b0, 1'b0};
        vecs[1] = '{1'b0, 9'h1FC,  9'd10,  8'd3,   8'd7,   1'b0, 1'b0};
        vecs[2] = '{1'b1, 9'd5,    9'd2,   8'd3,   8'd1,   1'b1, 1'b0};
        vecs[3] = '{1'b1, 9'd255,  9'h1FF, 8'd127, 8'h80,  1'b0, 1'b1};
        vecs[4] = '{1'b1, 9'h100,  9'd0,   8'h80,  8'h80,  1'b0, 1'b0};
        vecs[5] = '{1'b0, 9'd3,    9'h1FC, 8'hFF,  8'hFC,  1'b1, 1'b0};
        vecs[6] = '{1'b1, 9'd255,  9'd255, 8'hFF,  8'h00,  1'b0, 1'b1};
        vecs[7] = '{1'b0, 9'd0,    9'd0,   8'h00,  8'h00,  1'b0, 1'b0};
        vecs[8] = '{1'b1, 9'h100,  9'd255, 8'hFF,  8'h00,  1'b1, 1'b1};

        Rst = 1'b1; InValid = 1'b0; OutReady = 1'b1;
        AddSubMode = 1'b0; InputA = '0; InputB = '0;

        // Reset state
        repeat (2) @(negedge Clk);
        chk("rst InReady", {31'd0, InReady}, 32'd0);
        chk("rst OutValid", {31'd0, OutValid}, 32'd0);
        chk("rst ResultA", {24'd0, ResultA}, 32'd0);
        chk("rst ResultB", {24'd0, ResultB}, 32'd0);
        chk("rst flags", {30'd0, ErrParity, ErrOverflow}, 32'd0);
        Rst = 1'b0;
        #1 chk("post-rst InReady", {31'd0, InReady}, 32'd1);

        // One pair at a time, exact two-cycle latency
        for (int i = 0; i < NV; i++) begin
            @(negedge Clk);
            drive(vecs[i]);
            #1 chk($sformatf("v%0d InReady", i), {31'd0, InReady}, 32'd1);
            @(negedge Clk);
            InValid = 1'b0;
            chk($sformatf("v%0d early", i), {31'd0, OutValid}, 32'd0);
            @(negedge Clk);
            chk_out($sformatf("v%0d", i), vecs[i]);
        end
        @(negedge Clk);

        // Back-to-back streaming, one pair per cycle
        k = 0;
        for (int c = 0; c < NV + 4; c++) begin
            if (OutValid) begin
                if (k < NV) chk_out($sformatf("s%0d", k), vecs[k]);
                k++;
            end
            if (c < NV) begin
                drive(vecs[c]);
                #1 chk($sformatf("s%0d InReady", c), {31'd0, InReady}, 32'd1);
            end else begin
                InValid = 1'b0;
            end
            @(negedge Clk);
        end
        chk("stream count", k, NV);

        // Backpressure: three pairs offered, two buffered, outputs held
        OutReady = 1'b0;
        drive(vecs[0]);
        #1 chk("bp InReady0", {31'd0, InReady}, 32'd1);
        @(negedge Clk);
        drive(vecs[1]);
        #1 chk("bp InReady1", {31'd0, InReady}, 32'd1);
        @(negedge Clk);
        drive(vecs[2]);
        for (int s = 0; s < 3; s++) begin
            #1 chk($sformatf("bp stall%0d InReady", s), {31'd0, InReady}, 32'd0);
            chk_out($sformatf("bp hold%0d", s), vecs[0]);
            @(negedge Clk);
        end
        OutReady = 1'b1;
        #1 chk("bp release InReady", {31'd0, InReady}, 32'd1);
        k = 0;
        for (int c = 0; c < 8; c++) begin
            if (OutValid) begin
                if (k < 3) chk_out($sformatf("bp out%0d", k), vecs[k]);
                k++;
            end
            @(negedge Clk);
            InValid = 1'b0;
        end
        chk("bp count", k, 3);

        // Reset with two pairs in flight
        OutReady = 1'b0;
        drive(vecs[3]);
        @(negedge Clk);
        drive(vecs[6]);
        @(negedge Clk);
        InValid = 1'b0;
        Rst = 1'b1;
        #1 chk("flush InReady", {31'd0, InReady}, 32'd0);
        @(negedge Clk);
        chk("flush OutValid", {31'd0, OutValid}, 32'd0);
        chk("flush ResultA", {24'd0, ResultA}, 32'd0);
        chk("flush ResultB", {24'd0, ResultB}, 32'd0);
        chk("flush flags", {30'd0, ErrParity, ErrOverflow}, 32'd0);
        Rst = 1'b0;
        OutReady = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            chk($sformatf("flush stale%0d", c), {31'd0, OutValid}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
